// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-wide memory bus controller serving the load/store buffer and instruction fetch
// Optional MEM_CTRL_IO_STALL_EN: hold IO-space write beats while io_buffer_full is high.
module mem_ctrl #(
  parameter int         ADDR_W = 32,
  parameter logic [1:0] IO_SEL = 2'b11
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              lsb_valid,
  input  logic              lsb_wr,
  input  logic [2:0]        lsb_size,
  input  logic [ADDR_W-1:0] lsb_addr,
  input  logic [31:0]       lsb_value,
  output logic              lsb_ready,
  output logic [31:0]       lsb_res,
  input  logic              if_valid,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_clear,
  output logic              if_ready,
  output logic [31:0]       if_inst,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state;
  logic [2:0]        cnt, nbytes, req_size;
  logic              owner_if;
  logic [ADDR_W-1:0] req_addr, next_addr;
  logic [23:0]       req_hi, rbuf;
  logic [31:0]       load_res;
  logic [7:0]        din_eff, din_hold, next_byte;
  logic              frz_q, wr_q, lsb_rdy_q, if_rdy_q, full_eff, wr_stall;

`ifdef MEM_CTRL_IO_STALL_EN
  assign full_eff = io_buffer_full;
`else
  logic io_full_unused;
  assign io_full_unused = io_buffer_full;
  assign full_eff       = 1'b0;
`endif

  assign wr_stall  = full_eff && (mem_a[17:16] == IO_SEL);
  assign mem_wr    = wr_q && rdy_in && !wr_stall;
  assign lsb_ready = lsb_rdy_q && rdy_in;
  assign if_ready  = if_rdy_q && rdy_in;
  // After a freeze mem_din already reflects the advanced address; use the byte held on freeze entry.
  assign din_eff   = frz_q ? din_hold : mem_din;
  assign next_addr = req_addr + ADDR_W'(cnt) + ADDR_W'(1);

  always_comb begin
    nbytes = (req_size[1:0] == 2'd0) ? 3'd1 : (req_size[1:0] == 2'd1) ? 3'd2 : 3'd4;
    case (cnt)
      3'd0:    next_byte = req_hi[7:0];
      3'd1:    next_byte = req_hi[15:8];
      default: next_byte = req_hi[23:16];
    endcase
    case (req_size[1:0])
      2'd0:    load_res = {{24{!req_size[2] && din_eff[7]}}, din_eff};
      2'd1:    load_res = {{16{!req_size[2] && din_eff[7]}}, din_eff, rbuf[7:0]};
      default: load_res = {din_eff, rbuf};
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= S_IDLE;
      cnt       <= 3'd0;
      req_size  <= 3'd0;
      owner_if  <= 1'b0;
      req_addr  <= '0;
      req_hi    <= '0;
      rbuf      <= '0;
      din_hold  <= '0;
      frz_q     <= 1'b0;
      wr_q      <= 1'b0;
      lsb_rdy_q <= 1'b0;
      if_rdy_q  <= 1'b0;
      mem_a     <= '0;
      mem_dout  <= '0;
      lsb_res   <= '0;
      if_inst   <= '0;
    end else begin
      frz_q <= !rdy_in;
      if (!rdy_in && !frz_q) din_hold <= mem_din;
      if (rdy_in) begin
        case (state)
          S_IDLE: begin
            cnt <= 3'd0;
            if (lsb_valid) begin
              owner_if <= 1'b0;
              req_addr <= lsb_addr;
              req_hi   <= lsb_value[31:8];
              req_size <= lsb_size;
              mem_a    <= lsb_addr;
              if (lsb_wr) begin
                mem_dout <= lsb_value[7:0];
                wr_q     <= 1'b1;
                state    <= S_WRITE;
              end else begin
                state <= S_READ;
              end
            end else if (if_valid && !if_clear) begin
              owner_if <= 1'b1;
              req_addr <= if_addr;
              req_size <= 3'b010;
              mem_a    <= if_addr;
              state    <= S_READ;
            end
          end
          S_READ: begin
            if (owner_if && if_clear) begin
              state <= S_IDLE;
            end else begin
              // cnt counts cycles since the first address; byte cnt-1 is on mem_din now.
              case (cnt)
                3'd1:    rbuf[7:0]   <= din_eff;
                3'd2:    rbuf[15:8]  <= din_eff;
                3'd3:    rbuf[23:16] <= din_eff;
                default: ;
              endcase
              if (cnt == nbytes) begin
                state <= S_DONE;
                if (owner_if) begin
                  if_inst  <= load_res;
                  if_rdy_q <= 1'b1;
                end else begin
                  lsb_res   <= load_res;
                  lsb_rdy_q <= 1'b1;
                end
              end else begin
                cnt <= cnt + 3'd1;
                if ((cnt + 3'd1) < nbytes) mem_a <= next_addr;
              end
            end
          end
          S_WRITE: begin
            if (!wr_stall) begin
              if ((cnt + 3'd1) == nbytes) begin
                wr_q      <= 1'b0;
                lsb_rdy_q <= 1'b1;
                state     <= S_DONE;
              end else begin
                cnt      <= cnt + 3'd1;
                mem_a    <= next_addr;
                mem_dout <= next_byte;
              end
            end
          end
          default: begin
            lsb_rdy_q <= 1'b0;
            if_rdy_q  <= 1'b0;
            state     <= S_IDLE;
          end
        endcase
      end
    end
  end
endmodule
